// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and bit-timing formulas.
// The transmitter uses the same formulas so both sides agree on the baud period.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  localparam int DEFAULT_CLOCK_FREQ = 125_000_000;
  localparam int DEFAULT_BAUD_RATE  = 115_200;

  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int sample_time(input int clock_freq, input int baud_rate);
    return symbol_edge_time(clock_freq, baud_rate) / 2;
  endfunction

  localparam int DEFAULT_SYMBOL_EDGE_TIME = symbol_edge_time(DEFAULT_CLOCK_FREQ, DEFAULT_BAUD_RATE);
  localparam int DEFAULT_SAMPLE_TIME      = sample_time(DEFAULT_CLOCK_FREQ, DEFAULT_BAUD_RATE);

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Byte-output side of the UART receiver: ready/valid byte stream plus status pulses.
interface uart_rx_deframer_if;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overflow;
  logic       busy;

  modport master (
    output data_out,
    output data_out_valid,
    output framing_error,
    output overflow,
    output busy,
    input  data_out_ready
  );

  modport slave (
    input  data_out,
    input  data_out_valid,
    input  framing_error,
    input  overflow,
    input  busy,
    output data_out_ready
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; RESET_VALUE should match the
// idle level of the source so reset does not fabricate an edge.
module sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VALUE;
      r_sync <= RESET_VALUE;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: synchronizes the RX line, recovers frames with mid-bit
// sampling and hands bytes to a ready/valid consumer with framing/overrun pulses.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  uart_rx_deframer_if.master   rx
);

  localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int SAMPLE_TIME      = sample_time(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_TIME);

  logic             w_rx_s;
  rx_state_t        r_state,     w_state_next;
  logic [CNT_W-1:0] r_clk_cnt,   w_clk_cnt_next;
  logic [2:0]       r_bit_idx,   w_bit_idx_next;
  logic [7:0]       r_shift,     w_shift_next;
  logic [7:0]       r_data,      w_data_next;
  logic             r_valid,     w_valid_next;
  logic             r_deliver,   w_deliver_next;
  logic             r_ferr,      w_ferr_next;
  logic             r_ovf,       w_ovf_next;
  logic             r_rx_prev;

  sync_2ff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (serial_in),
    .o_q (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_deliver <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovf     <= 1'b0;
      r_rx_prev <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_clk_cnt <= w_clk_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_data    <= w_data_next;
      r_valid   <= w_valid_next;
      r_deliver <= w_deliver_next;
      r_ferr    <= w_ferr_next;
      r_ovf     <= w_ovf_next;
      r_rx_prev <= w_rx_s;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_clk_cnt_next = r_clk_cnt + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_data_next    = r_data;
    w_valid_next   = r_valid;
    w_deliver_next = 1'b0;
    w_ferr_next    = 1'b0;
    w_ovf_next     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_clk_cnt_next = '0;
        if (r_rx_prev && !w_rx_s) w_state_next = ST_START;
      end
      ST_START: begin
        // Restarting the count at mid-start-bit puts every later sample at mid-bit.
        if (r_clk_cnt == CNT_SAMPLE) begin
          w_clk_cnt_next = '0;
          w_bit_idx_next = '0;
          w_state_next   = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_clk_cnt == CNT_LAST) begin
          w_clk_cnt_next = '0;
          w_shift_next   = {w_rx_s, r_shift[7:1]};
          w_bit_idx_next = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (r_clk_cnt == CNT_LAST) begin
          w_clk_cnt_next = '0;
          if (w_rx_s) begin
            w_deliver_next = 1'b1;
            w_state_next   = ST_IDLE;
          end else begin
            w_ferr_next  = 1'b1;
            w_state_next = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        w_clk_cnt_next = '0;
        if (w_rx_s) w_state_next = ST_IDLE;
      end
      default: begin
        w_clk_cnt_next = '0;
        w_state_next   = ST_IDLE;
      end
    endcase

    // A consume and a new byte in the same cycle leave valid set with the new byte.
    if (r_valid && rx.data_out_ready) w_valid_next = 1'b0;
    if (r_deliver) begin
      if (!r_valid || rx.data_out_ready) begin
        w_data_next  = r_shift;
        w_valid_next = 1'b1;
      end else begin
        w_ovf_next = 1'b1;
      end
    end
  end

  assign rx.data_out       = r_data;
  assign rx.data_out_valid = r_valid;
  assign rx.framing_error  = r_ferr;
  assign rx.overflow       = r_ovf;
  assign rx.busy           = (r_state != ST_IDLE);

endmodule
